// File: rtl/bcd_timer_if.sv
// Control and display bundle for the BCD timer controller.
//   master : drives start/pause/clear/load/dir/preset digits, observes count/status
//   slave  : the controller side (receives commands, drives count/status)
// Signals:
//   start, pause, clear, load, dir  - level commands sampled each clk
//   preset_low, preset_high         - preset/target BCD digits
//   count_low, count_high           - current BCD count digits
//   tick, done                      - one-clk pulses (count step, terminal reached)
//   running                         - high while in RUN
//   state                           - IDLE=00, RUN=01, PAUSE=10, DONE=11
interface bcd_timer_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic       load;
  logic       dir;
  logic [3:0] preset_low;
  logic [3:0] preset_high;
  logic [3:0] count_low;
  logic [3:0] count_high;
  logic       tick;
  logic       running;
  logic       done;
  logic [1:0] state;

  modport master (
    output start, pause, clear, load, dir, preset_low, preset_high,
    input  count_low, count_high, tick, running, done, state
  );

  modport slave (
    input  start, pause, clear, load, dir, preset_low, preset_high,
    output count_low, count_high, tick, running, done, state
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Start/pause/clear/load sequencer around a two-digit BCD count (00..99).
// A prescaler divides clk into count steps; the count runs up to a
// programmed target or down from a preset to 00, then stops in DONE.
// Parameters:
//   PRESCALE - clk cycles per count step (1..65535)
//   PS_W     - prescaler width, 2^PS_W >= PRESCALE
// Ports:
//   clk - system clock (rising edge)
//   rst - asynchronous active-low reset
//   bus - bcd_timer_if.slave: commands in, count digits and status out
// All outputs are registered.
module bcd_timer_ctrl #(
  parameter int PRESCALE = 10,
  parameter int PS_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  bcd_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_t          state_q;
  logic [PS_W-1:0] ps_q;
  logic [3:0]      cnt_lo_q;
  logic [3:0]      cnt_hi_q;
  logic [3:0]      tgt_lo_q;
  logic [3:0]      tgt_hi_q;
  logic            dir_q;
  logic            tick_q;
  logic            done_q;
  logic            running_q;

  logic [7:0]      count_w;
  logic [7:0]      term_w;
  logic            at_term;
  logic [3:0]      pre_lo_c;
  logic [3:0]      pre_hi_c;

  // Non-BCD preset digits saturate to 9 rather than being passed through.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign count_w  = {cnt_hi_q, cnt_lo_q};
  // Counting down always ends at 00; counting up ends at the loaded target.
  assign term_w   = dir_q ? 8'h00 : {tgt_hi_q, tgt_lo_q};
  assign at_term  = (count_w == term_w);
  assign pre_lo_c = clamp_digit(bus.preset_low);
  assign pre_hi_c = clamp_digit(bus.preset_high);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ps_q      <= '0;
      cnt_lo_q  <= 4'd0;
      cnt_hi_q  <= 4'd0;
      tgt_lo_q  <= 4'd0;
      tgt_hi_q  <= 4'd0;
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.clear) begin
        state_q   <= IDLE;
        ps_q      <= '0;
        cnt_lo_q  <= 4'd0;
        cnt_hi_q  <= 4'd0;
        running_q <= 1'b0;
      end else if (bus.load) begin
        state_q   <= IDLE;
        ps_q      <= '0;
        tgt_lo_q  <= pre_lo_c;
        tgt_hi_q  <= pre_hi_c;
        dir_q     <= bus.dir;
        cnt_lo_q  <= bus.dir ? pre_lo_c : 4'd0;
        cnt_hi_q  <= bus.dir ? pre_hi_c : 4'd0;
        running_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // pause outranks start, so a held pause keeps the timer idle
            if (bus.start && !bus.pause) begin
              state_q   <= RUN;
              ps_q      <= '0;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            // Terminal check wins over a coinciding prescaler wrap, so the
            // count never steps past its end value.
            if (at_term) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              running_q <= 1'b0;
            end else if (bus.pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (ps_q == PS_LAST) begin
              ps_q   <= '0;
              tick_q <= 1'b1;
              if (dir_q) {cnt_hi_q, cnt_lo_q} <= bcd_dec(count_w);
              else       {cnt_hi_q, cnt_lo_q} <= bcd_inc(count_w);
            end else begin
              ps_q <= ps_q + PS_W'(1);
            end
          end
          PAUSE: begin
            // Prescaler is left untouched so partial progress resumes.
            if (bus.start && !bus.pause) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          DONE: begin
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count_low  = cnt_lo_q;
  assign bus.count_high = cnt_hi_q;
  assign bus.tick       = tick_q;
  assign bus.done       = done_q;
  assign bus.running    = running_q;
  assign bus.state      = state_q;

endmodule
